// File: rtl/ifid_stage_pkg.sv
// ifid_stage_pkg: shared CPU constants used by fetch/decode pipeline blocks.
//   NOP      - bubble encoding presented to decode
//   HALT_OP  - opcode field value (instr[15:11]) that stops fetch
//   ifidState_t - IF/ID register FSM state encoding
//   isHalt() - true when an instruction word carries the HALT opcode
package ifid_stage_pkg;

    localparam logic [15:0] NOP     = 16'h0800;
    localparam logic [4:0]  HALT_OP = 5'b00000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } ifidState_t;

    function automatic logic isHalt(input logic [15:0] word);
        return word[15:11] == HALT_OP;
    endfunction

endpackage

// File: rtl/dff.sv
// dff: codebase flop primitive, async active-high reset to a parameterised value.
//   clk - clock, rst - async reset (active-high), d - next value, q - stored value
module dff #(
    parameter int           W  = 1,
    parameter logic [W-1:0] RV = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= RV;
        else     q <= d;
    end

endmodule

// File: rtl/sat_counter8.sv
// sat_counter8: 8-bit up counter that sticks at 8'hFF; cleared only by reset.
//   clk - clock, rst - async reset (active-high), inc - count this edge, count - value
module sat_counter8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [7:0] count
);

    logic [7:0] countNext;

    assign countNext = (inc && count != 8'hFF) ? count + 8'd1 : count;

    dff #(.W(8), .RV(8'h00)) countReg (
        .clk(clk),
        .rst(rst),
        .d  (countNext),
        .q  (count)
    );

endmodule

// File: rtl/ifid_stage.sv
// ifid_stage: IF/ID pipeline register with stall/flush/halt control.
//   clk        - clock
//   rst        - async reset, active-low
//   instr, PC  - fetched instruction and its PC+2
//   fetchValid - instr/PC are valid this cycle
//   stall      - hold request from decode
//   flush      - squash from execute (taken branch/jump)
//   instrOut, PCOut, validOut - register contents presented to decode
//   pcWrite    - fetch may advance its PC
//   halted     - FSM is in HALTED
//   stallCount - saturating count of stalled edges
module ifid_stage
    import ifid_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic [15:0] PC,
    input  logic        fetchValid,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] instrOut,
    output logic [15:0] PCOut,
    output logic        validOut,
    output logic        pcWrite,
    output logic        halted,
    output logic [7:0]  stallCount
);

    // The flop primitive resets on a high level; adapt the active-low port.
    logic rstHigh;
    assign rstHigh = ~rst;

    ifidState_t  state, stateNext;
    logic [1:0]  stateQ;
    logic [15:0] instrNext, pcNext;
    logic        validNext;

    assign state = ifidState_t'(stateQ);

    always_comb begin
        stateNext = state;
        instrNext = instrOut;
        pcNext    = PCOut;
        validNext = validOut;
        if (flush) begin
            instrNext = NOP;
            pcNext    = 16'h0000;
            validNext = 1'b0;
            stateNext = RUN;
        end else if (stall) begin
            stateNext = (state == HALTED) ? HALTED : HOLD;
        end else if (state == HALTED) begin
            // Replaces the captured HALT with a bubble, then keeps reloading it.
            instrNext = NOP;
            validNext = 1'b0;
        end else if (fetchValid) begin
            instrNext = instr;
            pcNext    = PC;
            validNext = 1'b1;
            stateNext = isHalt(instr) ? HALTED : RUN;
        end else begin
            instrNext = NOP;
            validNext = 1'b0;
            stateNext = RUN;
        end
    end

    dff #(.W(2), .RV(RUN)) stateReg (
        .clk(clk),
        .rst(rstHigh),
        .d  (stateNext),
        .q  (stateQ)
    );

    dff #(.W(33), .RV({NOP, 16'h0000, 1'b0})) pipeReg (
        .clk(clk),
        .rst(rstHigh),
        .d  ({instrNext, pcNext, validNext}),
        .q  ({instrOut, PCOut, validOut})
    );

    // Flush wins over a simultaneous stall, so that edge is not counted.
    sat_counter8 stallCounter (
        .clk  (clk),
        .rst  (rstHigh),
        .inc  (stall && !flush),
        .count(stallCount)
    );

    assign pcWrite = !stall && (state != HALTED || flush);
    assign halted  = (state == HALTED);

endmodule

// File: tb/tb_ifid_stage.sv
module tb_ifid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic [15:0] PC;
    logic        fetchValid;
    logic        stall;
    logic        flush;
    logic [15:0] instrOut;
    logic [15:0] PCOut;
    logic        validOut;
    logic        pcWrite;
    logic        halted;
    logic [7:0]  stallCount;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ifid_stage dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .PC        (PC),
        .fetchValid(fetchValid),
        .stall     (stall),
        .flush     (flush),
        .instrOut  (instrOut),
        .PCOut     (PCOut),
        .validOut  (validOut),
        .pcWrite   (pcWrite),
        .halted    (halted),
        .stallCount(stallCount)
    );

    task automatic drive(input logic fv, input logic [15:0] i, input logic [15:0] p,
                         input logic st, input logic fl);
        fetchValid = fv;
        instr      = i;
        PC         = p;
        stall      = st;
        flush      = fl;
    endtask

    task automatic test_reset();
        drive(1'b1, 16'h1234, 16'h0010, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h2222, 16'h0012, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        total++; if (stallCount !== 8'd2) begin bad++; $display("FAIL pre_reset_count got=%0d exp=2", stallCount); end
        total++; if (instrOut !== 16'h1234) begin bad++; $display("FAIL pre_reset_instr got=%h exp=1234", instrOut); end
        #2 rst = 1'b0;
        #1;
        total++; if (instrOut !== 16'h0800) begin bad++; $display("FAIL reset_instr got=%h exp=0800", instrOut); end
        total++; if (PCOut !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h exp=0000", PCOut); end
        total++; if (validOut !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", validOut); end
        total++; if (stallCount !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", stallCount); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_stream();
        drive(1'b1, 16'h4123, 16'h0002, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (instrOut !== 16'h4123) begin bad++; $display("FAIL stream_instr got=%h exp=4123", instrOut); end
        total++; if (PCOut !== 16'h0002) begin bad++; $display("FAIL stream_pc got=%h exp=0002", PCOut); end
        total++; if (validOut !== 1'b1) begin bad++; $display("FAIL stream_valid got=%b exp=1", validOut); end
        total++; if (pcWrite !== 1'b1) begin bad++; $display("FAIL stream_pcwrite got=%b exp=1", pcWrite); end
        drive(1'b1, 16'h5abc, 16'h0004, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (instrOut !== 16'h5abc || PCOut !== 16'h0004) begin bad++; $display("FAIL stream2 got=%h/%h exp=5abc/0004", instrOut, PCOut); end
        drive(1'b0, 16'h9999, 16'h0006, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (instrOut !== 16'h0800 || validOut !== 1'b0 || PCOut !== 16'h0004) begin bad++; $display("FAIL bubble got=%h/%b/%h exp=0800/0/0004", instrOut, validOut, PCOut); end
    endtask

    task automatic test_stall();
        drive(1'b1, 16'h6111, 16'h0006, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'h7000 + 16'(k), 16'h0100 + 16'(k), 1'b1, 1'b0);
            #1;
            total++; if (pcWrite !== 1'b0) begin bad++; $display("FAIL stall_pcwrite[%0d] got=%b exp=0", k, pcWrite); end
            @(negedge clk);
            total++; if (instrOut !== 16'h6111 || PCOut !== 16'h0006 || validOut !== 1'b1) begin bad++; $display("FAIL stall_hold[%0d] got=%h/%h/%b exp=6111/0006/1", k, instrOut, PCOut, validOut); end
        end
        total++; if (stallCount !== 8'd3) begin bad++; $display("FAIL stall_count got=%0d exp=3", stallCount); end
        drive(1'b1, 16'h7222, 16'h0008, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (instrOut !== 16'h7222 || PCOut !== 16'h0008 || validOut !== 1'b1) begin bad++; $display("FAIL stall_release got=%h/%h/%b exp=7222/0008/1", instrOut, PCOut, validOut); end
    endtask

    task automatic test_halt();
        drive(1'b1, 16'h0000, 16'h0020, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", halted); end
        total++; if (pcWrite !== 1'b0) begin bad++; $display("FAIL halt_pcwrite got=%b exp=0", pcWrite); end
        total++; if (instrOut !== 16'h0000 || validOut !== 1'b1) begin bad++; $display("FAIL halt_capture got=%h/%b exp=0000/1", instrOut, validOut); end
        drive(1'b1, 16'h4444, 16'h0022, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (instrOut !== 16'h0800 || validOut !== 1'b0 || PCOut !== 16'h0020) begin bad++; $display("FAIL halt_bubble got=%h/%b/%h exp=0800/0/0020", instrOut, validOut, PCOut); end
        @(negedge clk);
        total++; if (instrOut !== 16'h0800 || validOut !== 1'b0 || halted !== 1'b1) begin bad++; $display("FAIL halt_ignore got=%h/%b/%b exp=0800/0/1", instrOut, validOut, halted); end
        drive(1'b1, 16'h4444, 16'h0022, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (halted !== 1'b1 || stallCount !== 8'd4) begin bad++; $display("FAIL halt_stall got=%b/%0d exp=1/4", halted, stallCount); end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        #1;
        total++; if (halted !== 1'b0 || pcWrite !== 1'b1) begin bad++; $display("FAIL halt_flush got=%b/%b exp=0/1", halted, pcWrite); end
        total++; if (instrOut !== 16'h0800 || PCOut !== 16'h0000) begin bad++; $display("FAIL halt_flush_regs got=%h/%h exp=0800/0000", instrOut, PCOut); end
        @(negedge clk);
    endtask

    task automatic test_flush_vs_stall();
        drive(1'b1, 16'h0123, 16'h0030, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL fvs_halt got=%b exp=1", halted); end
        drive(1'b1, 16'h4567, 16'h0032, 1'b1, 1'b1);
        @(negedge clk);
        total++; if (instrOut !== 16'h0800 || validOut !== 1'b0 || PCOut !== 16'h0000) begin bad++; $display("FAIL fvs_regs got=%h/%b/%h exp=0800/0/0000", instrOut, validOut, PCOut); end
        total++; if (stallCount !== 8'd4) begin bad++; $display("FAIL fvs_count got=%0d exp=4", stallCount); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL fvs_state got=%b exp=0", halted); end
        drive(1'b1, 16'h4123, 16'h0034, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (instrOut !== 16'h4123 || validOut !== 1'b1) begin bad++; $display("FAIL fvs_resume got=%h/%b exp=4123/1", instrOut, validOut); end
    endtask

    task automatic test_reset_mid_halt();
        drive(1'b1, 16'h07ff, 16'h0040, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h07ff, 16'h0040, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (halted !== 1'b1 || stallCount !== 8'd5) begin bad++; $display("FAIL rmh_pre got=%b/%0d exp=1/5", halted, stallCount); end
        #2 rst = 1'b0;
        #1;
        total++; if (halted !== 1'b0 || stallCount !== 8'd0 || instrOut !== 16'h0800) begin bad++; $display("FAIL rmh_reset got=%b/%0d/%h exp=0/0/0800", halted, stallCount, instrOut); end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 16'h1abc, 16'h0050, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (instrOut !== 16'h1abc || PCOut !== 16'h0050 || validOut !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL rmh_after got=%h/%h/%b/%b exp=1abc/0050/1/0", instrOut, PCOut, validOut, halted); end
    endtask

    task automatic test_saturation();
        drive(1'b1, 16'h3333, 16'h0060, 1'b1, 1'b0);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k == 254) begin
                total++; if (stallCount !== 8'hFF) begin bad++; $display("FAIL sat_255 got=%h exp=ff", stallCount); end
            end
        end
        total++; if (stallCount !== 8'hFF) begin bad++; $display("FAIL sat_300 got=%h exp=ff", stallCount); end
        total++; if (instrOut !== 16'h1abc) begin bad++; $display("FAIL sat_hold got=%h exp=1abc", instrOut); end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_halt();
        test_flush_vs_stall();
        test_reset_mid_halt();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifid_stage.md
IFID_STAGE -- requirements
Module: ifid_stage

Interface
REQ-001 The block SHALL have the following ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- instr  in  16  fetched instruction word
- PC  in  16  PC+2 of the fetched instruction
- fetchValid  in  1  instr/PC are valid this cycle
- stall  in  1  hazard hold request from decode
- flush  in  1  taken branch/jump from execute; squash the fetched instruction
- instrOut  out  16  instruction presented to decode
- PCOut  out  16  PC+2 presented to decode
- validOut  out  1  instrOut is a real instruction, not a bubble
- pcWrite  out  1  fetch may advance PC this cycle
- halted  out  1  block is in HALTED state
- stallCount  out  8  saturating count of stall cycles
REQ-002 Clock and reset SHALL be the single clock clk and the asynchronous, active-low reset rst; no other clock or reset exists.

Function
REQ-003 Constants SHALL be: NOP = 16'h0800; HALT opcode = instr[15:11] == 5'b00000.
REQ-004 The FSM SHALL have states RUN, HOLD and HALTED.
REQ-005 Register update priority SHALL be, highest first: flush, stall, fetchValid, idle.
REQ-006 flush SHALL load instrOut=NOP, PCOut=0 and validOut=0 at the next edge, in any state, and SHALL force next state RUN.
REQ-007 stall without flush SHALL hold instrOut, PCOut and validOut unchanged; next state SHALL be HOLD, except that HALTED SHALL remain HALTED.
REQ-008 In RUN or HOLD, fetchValid with no stall or flush SHALL load instr, PC and validOut=1; next state SHALL be HALTED if instr is a HALT, else RUN.
REQ-009 In RUN or HOLD, no fetchValid, no stall and no flush SHALL load a bubble (instrOut=NOP, validOut=0; PCOut held); next state SHALL be RUN.
REQ-010 In HALTED with no stall or flush, the first edge SHALL replace the captured HALT with a bubble, and the block SHALL then hold the bubble; fetchValid SHALL be ignored while HALTED.
REQ-011 pcWrite SHALL be combinational: !stall && (state != HALTED || flush).
REQ-012 halted SHALL be 1 exactly when state == HALTED.
REQ-013 stallCount SHALL increment on each edge where stall=1 and flush=0, SHALL saturate at 8'hFF, and SHALL clear only on reset.
REQ-014 Latency instr -> instrOut SHALL be exactly one cycle when not stalled.
REQ-015 Simultaneous stall and flush SHALL act as flush and SHALL NOT increment stallCount.

Reset
REQ-016 Asserting rst low SHALL immediately force instrOut=NOP, PCOut=0, validOut=0, stallCount=0 and state RUN, independent of clk.
REQ-017 Reset asserted mid-stall or mid-halt SHALL discard the held contents; the first edge after deassertion SHALL follow REQ-005..REQ-010 from state RUN.

Structure
REQ-018 The NOP encoding, the HALT opcode and the FSM state encodings SHALL live in the shared CPU constants package, which decode and this block both use.
REQ-019 Storage SHALL use the codebase dff primitive for every flop, with a local reset-polarity adapter.
REQ-020 The saturating stall counter SHALL be one sub-module, sat_counter8.

Verification
REQ-021 Reset: rst=0 mid-cycle -> instrOut=16'h0800, validOut=0, PCOut=0, stallCount=0 with no clock edge.
REQ-022 Stream: fetchValid=1, instr=16'h4123, PC=16'h0002 -> next cycle instrOut=16'h4123, PCOut=16'h0002, validOut=1.
REQ-023 Stall: stall=1 for 3 cycles while instr changes -> outputs held, pcWrite=0, stallCount=3.
REQ-024 Flush vs stall: stall=1 and flush=1 on the same edge -> instrOut=NOP, validOut=0, stallCount unchanged, state RUN.
REQ-025 Halt: instr=16'h0000 captured -> halted=1, pcWrite=0; next edge gives instrOut=NOP, validOut=0; later fetchValid is ignored. A subsequent flush -> halted=0, pcWrite=1.
REQ-026 Saturation: 300 consecutive stall cycles -> stallCount=8'hFF.
